// File: rtl/afw_climate_fsm.sv
`default_nettype none
// ============================================================================
// afw_climate_fsm : registered temperature code driving a 4-state FAN/AC/WIND
//                   climate FSM with hysteresis, minimum dwell and window settle.
// Optional sensor watchdog: define AFW_WDOG_EN.
// Revision: 1.0
// ============================================================================
module afw_climate_fsm #(
   parameter int TEMP_W    = 4,
   parameter int FAN_TH    = 7,
   parameter int AC_TH     = 11,
   parameter int HYST      = 1,
   parameter int MIN_DWELL = 4,
   parameter int SETTLE    = 3,
   parameter int WDOG_CYC  = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [TEMP_W-1:0] TEMP,
   input  logic              TEMP_VLD,
   output logic              FAN,
   output logic              AC,
   output logic              WIND,
   output logic [1:0]        STATE,
   output logic              FAULT
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_VENT    = 2'd1,
      S_PRECOOL = 2'd2,
      S_COOL    = 2'd3
   } state_t;

   localparam int TW1     = TEMP_W + 1;
   localparam int CNT_MAX = (MIN_DWELL > SETTLE) ? MIN_DWELL : SETTLE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Extra headroom bit keeps TH-HYST from wrapping.
   localparam logic [TW1-1:0]   C_FAN_ON      = TW1'(FAN_TH);
   localparam logic [TW1-1:0]   C_AC_ON       = TW1'(AC_TH);
   localparam logic [TW1-1:0]   C_FAN_OFF     = TW1'(FAN_TH - HYST);
   localparam logic [TW1-1:0]   C_AC_OFF      = TW1'(AC_TH - HYST);
   localparam logic [CNT_W-1:0] C_DWELL       = CNT_W'(MIN_DWELL);
   localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE - 1);

   state_t              state_q, state_d;
   logic [TEMP_W-1:0]   t_q, t_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    cnt_sat;
   logic [TW1-1:0]      t_ext;
   logic                dwell_ok;
   logic                wd_hold;

`ifdef AFW_WDOG_EN
   localparam int             WD_W   = $clog2(WDOG_CYC + 1);
   localparam logic [WD_W-1:0] C_WDOG = WD_W'(WDOG_CYC);

   logic [WD_W-1:0] wdog_q, wdog_d;

   always_comb begin
      if (TEMP_VLD)
         wdog_d = '0;
      else if (wdog_q != C_WDOG)
         wdog_d = wdog_q + WD_W'(1);
      else
         wdog_d = wdog_q;
   end

   always_ff @(posedge CLK) begin
      if (RST)
         wdog_q <= '0;
      else
         wdog_q <= wdog_d;
   end

   // Hold in VENT with a cleared dwell count while faulted, including the
   // edge the fault appears and the edge it clears.
   assign FAULT   = (wdog_q == C_WDOG);
   assign wd_hold = FAULT | (wdog_d == C_WDOG);
`else
   logic unused_wdog_cyc;
   assign unused_wdog_cyc = ^WDOG_CYC;
   assign FAULT           = 1'b0;
   assign wd_hold         = 1'b0;
`endif

   assign t_ext    = {1'b0, t_q};
   assign dwell_ok = (cnt_q == C_DWELL);

   always_comb begin
      t_d     = TEMP_VLD ? TEMP : t_q;
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (dwell_ok && t_ext >= C_AC_ON)       state_d = S_PRECOOL;
            else if (dwell_ok && t_ext >= C_FAN_ON) state_d = S_VENT;
         end
         S_VENT: begin
            if (dwell_ok && t_ext >= C_AC_ON)       state_d = S_PRECOOL;
            else if (dwell_ok && t_ext < C_FAN_OFF) state_d = S_IDLE;
         end
         S_PRECOOL: begin
            if (cnt_q == C_SETTLE_LAST)             state_d = S_COOL;
         end
         S_COOL: begin
            if (dwell_ok && t_ext < C_AC_OFF)       state_d = S_VENT;
         end
         default:                                   state_d = S_IDLE;
      endcase
      if (wd_hold)
         state_d = S_VENT;

      // PRECOOL reuses the dwell counter as its settle timer.
      cnt_sat = (state_q == S_PRECOOL) ? C_SETTLE_LAST : C_DWELL;
      if (state_d != state_q || wd_hold)
         cnt_d = '0;
      else if (cnt_q != cnt_sat)
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         cnt_q   <= cnt_d;
      end
   end

   assign STATE = state_q;
   assign FAN   = (state_q == S_VENT) || (state_q == S_PRECOOL);
   assign WIND  = (state_q == S_VENT);
   assign AC    = (state_q == S_COOL);

endmodule
`default_nettype wire

// File: tb/tb_afw_climate_fsm.sv
`default_nettype none
// ============================================================================
// tb_afw_climate_fsm : directed + randomized bench for afw_climate_fsm against
//                      a cycle-level behavioural model of the climate rules.
// Revision: 1.0
// ============================================================================
module tb_afw_climate_fsm;

   localparam int TEMP_W    = 4;
   localparam int FAN_TH    = 7;
   localparam int AC_TH     = 11;
   localparam int HYST      = 1;
   localparam int MIN_DWELL = 4;
   localparam int SETTLE    = 3;
   localparam int WDOG_CYC  = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [TEMP_W-1:0] temp;
   logic              vld;
   logic              fan, ac, wind, fault;
   logic [1:0]        state_o;

   int n_checks = 0;
   int n_fail   = 0;

   afw_climate_fsm #(
      .TEMP_W(TEMP_W), .FAN_TH(FAN_TH), .AC_TH(AC_TH), .HYST(HYST),
      .MIN_DWELL(MIN_DWELL), .SETTLE(SETTLE), .WDOG_CYC(WDOG_CYC)
   ) dut (
      .CLK(clk), .RST(rst), .TEMP(temp), .TEMP_VLD(vld),
      .FAN(fan), .AC(ac), .WIND(wind), .STATE(state_o), .FAULT(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural model: state as 0..3, time-in-state as an unbounded age.
   int m_t, m_st, m_age, m_wd;
   bit m_fault;
   bit model_live = 1'b0;

   always @(posedge clk) begin
      int  ns;
      bit  dok, forced;
      if (rst) begin
         m_t = 0; m_st = 0; m_age = 0; m_wd = 0; m_fault = 1'b0;
      end else begin
         ns  = m_st;
         dok = (m_age >= MIN_DWELL);
         if (m_st == 0) begin
            if (dok && m_t >= AC_TH) ns = 2;
            else if (dok && m_t >= FAN_TH) ns = 1;
         end else if (m_st == 1) begin
            if (dok && m_t >= AC_TH) ns = 2;
            else if (dok && m_t < FAN_TH - HYST) ns = 0;
         end else if (m_st == 2) begin
            if (m_age + 1 >= SETTLE) ns = 3;
         end else begin
            if (dok && m_t < AC_TH - HYST) ns = 1;
         end
         forced = 1'b0;
`ifdef AFW_WDOG_EN
         forced = m_fault;
         m_wd   = vld ? 0 : ((m_wd < WDOG_CYC) ? m_wd + 1 : m_wd);
         m_fault = (m_wd == WDOG_CYC);
         if (m_fault) forced = 1'b1;
         if (forced) ns = 1;
`endif
         if (ns != m_st || forced) m_age = 0;
         else m_age++;
         m_st = ns;
         if (vld) m_t = int'(temp);
      end
      model_live = 1'b1;
   end

   always @(negedge clk) begin
      logic [7:0] exp_v;
      if (model_live) begin
         exp_v = {3'b000, m_st[1:0], (m_st == 1 || m_st == 2), (m_st == 3), (m_st == 1)};
         check("model_cmp", {3'b000, state_o, fan, ac, wind}, exp_v);
         check("model_fault", {7'd0, fault}, {7'd0, m_fault});
         check("ac_wind_excl", {7'd0, ac & wind}, 8'd0);
      end
   end

   initial begin
      int prev_st, last_chg, min_gap, n_chg, waited;
      rst = 1'b1; temp = '0; vld = 1'b0;
      cyc(3);
      check("rst_state", {6'd0, state_o}, 8'd0);
      check("rst_outs", {4'd0, fan, ac, wind, fault}, 8'd0);

      rst = 1'b0; temp = 4'd3; vld = 1'b1; cyc(1); vld = 1'b0;
      cyc(5);
      check("idle_t3", {6'd0, state_o}, 8'd0);

      temp = 4'd8; vld = 1'b1; cyc(1); vld = 1'b0;
      check("vent_latency", {6'd0, state_o}, 8'd0);
      cyc(1);
      check("vent_state", {6'd0, state_o}, 8'd1);
      check("vent_outs", {5'd0, fan, ac, wind}, 8'b101);

      cyc(5);
      temp = 4'd12; vld = 1'b1; cyc(1); vld = 1'b0;
      for (int i = 0; i < SETTLE; i++) begin
         cyc(1);
         check("precool", {3'd0, state_o, fan, ac, wind}, {3'd0, 2'd2, 3'b100});
      end
      cyc(1);
      check("cool", {3'd0, state_o, fan, ac, wind}, {3'd0, 2'd3, 3'b010});

      cyc(5);
      temp = 4'd10; vld = 1'b1; cyc(1); vld = 1'b0;
      cyc(4);
      check("cool_hyst_10", {6'd0, state_o}, 8'd3);
      temp = 4'd9; vld = 1'b1; cyc(1); vld = 1'b0;
      cyc(1);
      check("cool_to_vent_9", {6'd0, state_o}, 8'd1);
      temp = 4'd5; vld = 1'b1; cyc(1); vld = 1'b0;
      for (int i = 0; i < MIN_DWELL; i++) begin
         check("vent_dwell", {6'd0, state_o}, 8'd1);
         cyc(1);
      end
      check("vent_to_idle", {6'd0, state_o}, 8'd0);

      cyc(6);
      prev_st = int'(state_o); last_chg = 0; min_gap = 1000; n_chg = 0;
      for (int i = 1; i <= 30; i++) begin
         temp = (i % 2 == 1) ? 4'd8 : 4'd5; vld = 1'b1; cyc(1);
         if (int'(state_o) != prev_st) begin
            if (n_chg > 0 && i - last_chg < min_gap) min_gap = i - last_chg;
            n_chg++; last_chg = i; prev_st = int'(state_o);
         end
      end
      vld = 1'b0;
      check("dwell_moved", {7'd0, n_chg > 1}, 8'd1);
      check("dwell_gap", {7'd0, min_gap >= MIN_DWELL}, 8'd1);

      temp = 4'd15; vld = 1'b1; cyc(1); vld = 1'b0;
      waited = 0;
      while (state_o != 2'd2 && waited < 40) begin cyc(1); waited++; end
      check("reach_precool", {6'd0, state_o}, 8'd2);
      rst = 1'b1; cyc(1); rst = 1'b0;
      check("rst_in_precool", {4'd0, state_o, ac, fan}, 8'd0);

`ifdef AFW_WDOG_EN
      temp = 4'd15; vld = 1'b1; cyc(1); vld = 1'b0;
      waited = 0;
      while (state_o != 2'd3 && waited < 40) begin cyc(1); waited++; end
      check("reach_cool", {6'd0, state_o}, 8'd3);
      vld = 1'b1; cyc(1); vld = 1'b0;
      cyc(WDOG_CYC - 1);
      check("wdog_early", {7'd0, fault}, 8'd0);
      cyc(1);
      check("wdog_fault", {4'd0, fault, state_o, ac}, {4'd0, 1'b1, 2'd1, 1'b0});
      temp = 4'd3; vld = 1'b1; cyc(1); vld = 1'b0;
      check("wdog_clear", {5'd0, fault, state_o}, {5'd0, 1'b0, 2'd1});
`endif

      for (int seg = 0; seg < 60; seg++) begin
         int mode, len;
         mode = $urandom_range(0, 3);
         len  = $urandom_range(10, 80);
         for (int i = 0; i < len; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            temp = 4'($urandom_range(0, 15));
            case (mode)
               0:       vld = ($urandom_range(0, 1) == 0);
               1:       vld = ($urandom_range(0, 7) == 0);
               2:       vld = 1'b0;
               default: vld = 1'b1;
            endcase
            cyc(1);
         end
      end
      rst = 1'b0; vld = 1'b0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
